// File: rtl/pc_sequencer_if.sv
// Signal bundle between the next-PC sequencer and the rest of the CPU front end:
// PC register, redirect producers and the instruction-memory fetch handshake.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        hazard_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        flush_if;
  logic        flush_id;
  logic        if_timeout;
  logic [31:0] redirect_cnt;

  // Sequencer side
  modport master (
    input  pc_cur, hazard_stall, br_taken, br_target, jmp_valid, jmp_target,
    input  exc_req, eret_req, epc, imem_ack,
    output imem_req, pc_in, pc_stall, flush_if, flush_id, if_timeout, redirect_cnt
  );

  // CPU / memory side
  modport slave (
    output pc_cur, hazard_stall, br_taken, br_target, jmp_valid, jmp_target,
    output exc_req, eret_req, epc, imem_ack,
    input  imem_req, pc_in, pc_stall, flush_if, flush_id, if_timeout, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates exception/eret/branch/jump redirects, sequences the
// single-outstanding instruction fetch and holds any redirect the PC cannot take yet.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'hF000_0000,
  parameter logic [31:0] EXC_VEC    = 32'h8000_0180,
  parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.master bus
);

  localparam logic [1:0] LVL_JMP  = 2'd0;
  localparam logic [1:0] LVL_BR   = 2'd1;
  localparam logic [1:0] LVL_ERET = 2'd2;
  localparam logic [1:0] LVL_EXC  = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        pend_vld_r;
  logic        pend_vld_nxt_s;
  logic [1:0]  pend_lvl_r;
  logic [1:0]  pend_lvl_nxt_s;
  logic [31:0] pend_tgt_r;
  logic [31:0] pend_tgt_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_nxt_s;
  logic        if_timeout_r;
  logic        if_timeout_nxt_s;
  logic [31:0] redirect_cnt_r;
  logic [31:0] redirect_cnt_nxt_s;

  logic        live_vld_s;
  logic [1:0]  live_lvl_s;
  logic [31:0] live_tgt_s;
  logic        eff_vld_s;
  logic [1:0]  eff_lvl_s;
  logic [31:0] eff_tgt_s;
  logic        fetching_s;
  logic        adv_s;

  // Pick the highest-priority redirect source asserted this cycle
  always_comb begin
    live_vld_s = 1'b1;
    live_lvl_s = LVL_JMP;
    live_tgt_s = bus.jmp_target;
    if (bus.exc_req) begin
      live_lvl_s = LVL_EXC;
      live_tgt_s = EXC_VEC;
    end else if (bus.eret_req) begin
      live_lvl_s = LVL_ERET;
      live_tgt_s = bus.epc;
    end else if (bus.br_taken) begin
      live_lvl_s = LVL_BR;
      live_tgt_s = bus.br_target;
    end else if (bus.jmp_valid) begin
      live_lvl_s = LVL_JMP;
      live_tgt_s = bus.jmp_target;
    end else begin
      live_vld_s = 1'b0;
    end
  end

  // A held redirect wins ties against a live one of the same level
  always_comb begin
    eff_vld_s = live_vld_s;
    eff_lvl_s = live_lvl_s;
    eff_tgt_s = live_tgt_s;
    if (pend_vld_r && (!live_vld_s || (pend_lvl_r >= live_lvl_s))) begin
      eff_vld_s = 1'b1;
      eff_lvl_s = pend_lvl_r;
      eff_tgt_s = pend_tgt_r;
    end else begin
      eff_vld_s = live_vld_s;
    end
  end

  // Fetch FSM next state, wait counter and sticky timeout
  always_comb begin
    state_nxt_s      = state_r;
    wait_cnt_nxt_s   = wait_cnt_r;
    if_timeout_nxt_s = if_timeout_r;
    fetching_s       = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s    = ST_FETCH;
        wait_cnt_nxt_s = 8'd0;
      end
      ST_FETCH: begin
        fetching_s = 1'b1;
        if (bus.imem_ack) begin
          state_nxt_s    = ST_FETCH;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = 8'd1;
        end
      end
      ST_WAIT: begin
        fetching_s = 1'b1;
        if (bus.imem_ack) begin
          state_nxt_s    = ST_FETCH;
          wait_cnt_nxt_s = 8'd0;
        end else if (wait_cnt_r < WAIT_LIMIT) begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end else begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = WAIT_LIMIT;
        end
        if (wait_cnt_r >= WAIT_LIMIT) begin
          if_timeout_nxt_s = 1'b1;
        end else begin
          if_timeout_nxt_s = if_timeout_r;
        end
      end
      default: begin
        state_nxt_s    = ST_BOOT;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Exceptions and eret are allowed to bypass the load-use stall
  always_comb begin
    adv_s = !reset && fetching_s && bus.imem_ack &&
            (!bus.hazard_stall || (eff_vld_s && (eff_lvl_s >= LVL_ERET)));
  end

  // Outputs towards PC register, pipeline and instruction memory
  always_comb begin
    bus.imem_req     = fetching_s && !reset;
    bus.pc_stall     = !adv_s;
    bus.flush_if     = adv_s && eff_vld_s;
    bus.flush_id     = adv_s && eff_vld_s && (eff_lvl_s != LVL_JMP);
    bus.if_timeout   = if_timeout_r;
    bus.redirect_cnt = redirect_cnt_r;
    if (reset || (state_r == ST_BOOT)) begin
      bus.pc_in = RESET_PC;
    end else if (!adv_s) begin
      bus.pc_in = bus.pc_cur;
    end else if (eff_vld_s) begin
      bus.pc_in = eff_tgt_s;
    end else begin
      bus.pc_in = bus.pc_cur + 32'd4;
    end
  end

  // Consume the redirect on advance, otherwise hold the strongest one seen
  always_comb begin
    pend_vld_nxt_s     = pend_vld_r;
    pend_lvl_nxt_s     = pend_lvl_r;
    pend_tgt_nxt_s     = pend_tgt_r;
    redirect_cnt_nxt_s = redirect_cnt_r;
    if (adv_s) begin
      pend_vld_nxt_s     = 1'b0;
      redirect_cnt_nxt_s = eff_vld_s ? (redirect_cnt_r + 32'd1) : redirect_cnt_r;
    end else if (live_vld_s && (!pend_vld_r || (live_lvl_s > pend_lvl_r))) begin
      pend_vld_nxt_s = 1'b1;
      pend_lvl_nxt_s = live_lvl_s;
      pend_tgt_nxt_s = live_tgt_s;
    end else begin
      pend_vld_nxt_s = pend_vld_r;
    end
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_BOOT;
      pend_vld_r     <= 1'b0;
      pend_lvl_r     <= LVL_JMP;
      pend_tgt_r     <= 32'd0;
      wait_cnt_r     <= 8'd0;
      if_timeout_r   <= 1'b0;
      redirect_cnt_r <= 32'd0;
    end else begin
      state_r        <= state_nxt_s;
      pend_vld_r     <= pend_vld_nxt_s;
      pend_lvl_r     <= pend_lvl_nxt_s;
      pend_tgt_r     <= pend_tgt_nxt_s;
      wait_cnt_r     <= wait_cnt_nxt_s;
      if_timeout_r   <= if_timeout_nxt_s;
      redirect_cnt_r <= redirect_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, timeout sequence, then randomized
// traffic against a cycle-level reference model of the redirect/fetch rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'hF000_0000;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0180;
  localparam int          WLIM     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC  (RESET_PC),
    .EXC_VEC   (EXC_VEC),
    .WAIT_LIMIT(8'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // src bits: {exc, eret, br, jmp}
  task automatic drive(input logic rst, input logic ack, input logic hz, input logic [3:0] src,
                       input logic [31:0] pc, input logic [31:0] brt, input logic [31:0] jt,
                       input logic [31:0] ep);
    @(negedge clk);
    reset            = rst;
    bus.imem_ack     = ack;
    bus.hazard_stall = hz;
    bus.exc_req      = src[3];
    bus.eret_req     = src[2];
    bus.br_taken     = src[1];
    bus.jmp_valid    = src[0];
    bus.pc_cur       = pc;
    bus.br_target    = brt;
    bus.jmp_target   = jt;
    bus.epc          = ep;
    #1;
  endtask

  // Outputs that have a fixed value whenever reset is asserted
  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pc_in"}, bus.pc_in, RESET_PC);
    chk({tag, ".pc_stall"}, {31'd0, bus.pc_stall}, 32'd1);
    chk({tag, ".imem_req"}, {31'd0, bus.imem_req}, 32'd0);
    chk({tag, ".flush"}, {30'd0, bus.flush_if, bus.flush_id}, 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic        hz;
    logic [3:0]  src;
    logic [31:0] pc;
    logic [31:0] brt;
    logic [31:0] jt;
    logic [31:0] ep;
    logic [31:0] e_pc;
    logic [3:0]  e_flags;  // {pc_stall, imem_req, flush_if, flush_id}
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic hz, input logic [3:0] src,
                              input logic [31:0] pc, input logic [31:0] brt, input logic [31:0] jt,
                              input logic [31:0] ep, input logic [31:0] e_pc, input logic [3:0] e_flags,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.hz = hz; v.src = src; v.pc = pc; v.brt = brt; v.jt = jt; v.ep = ep;
    v.e_pc = e_pc; v.e_flags = e_flags; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[$];

  // Reference model state
  int          m_pend;
  logic [31:0] m_ptgt;
  bit          m_boot;
  int          m_waits;
  bit          m_tmo;
  logic [31:0] m_cnt;
  logic [31:0] tg [4];

  initial begin
    logic [31:0] next_pc;
    logic [31:0] pc, etgt, exp_pc;
    logic [3:0]  src;
    logic        rst, ack, hz, adv;
    int          live, eff;

    reset = 1'b1;
    bus.imem_ack = 1'b0; bus.hazard_stall = 1'b0; bus.exc_req = 1'b0; bus.eret_req = 1'b0;
    bus.br_taken = 1'b0; bus.jmp_valid = 1'b0; bus.pc_cur = RESET_PC;
    bus.br_target = 32'd0; bus.jmp_target = 32'd0; bus.epc = 32'd0;

    // rst ack hz src pc brt jt epc | pc_in {stall,req,fif,fid} redirect_cnt
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0, RESET_PC, 4'b1000, 32'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0, RESET_PC, 4'b1000, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0, 32'hF000_0004, 4'b0100, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0010, 32'hF000_0004, 32'h100, 32'h0, 32'h0, 32'hF000_0004, 4'b1100, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0000, 32'hF000_0004, 32'h0, 32'h0, 32'h0, 32'hF000_0004, 4'b1100, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0000, 32'hF000_0004, 32'h0, 32'h0, 32'h0, 32'hF000_0004, 4'b1100, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'hF000_0004, 32'h0, 32'h0, 32'h0, 32'h100, 4'b0111, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1001, 32'h100, 32'h0, 32'h2000, 32'h0, EXC_VEC, 4'b0111, 32'd1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0000, EXC_VEC, 32'h0, 32'h0, 32'h0, EXC_VEC, 4'b1100, 32'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, EXC_VEC, 32'h0, 32'h0, 32'h0, EXC_VEC, 4'b1100, 32'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, EXC_VEC, 32'h0, 32'h3000, 32'h0, EXC_VEC, 4'b1100, 32'd2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, EXC_VEC, 32'h0, 32'h0, 32'h0, EXC_VEC, 4'b1100, 32'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, EXC_VEC, 32'h0, 32'h0, 32'h0, 32'h3000, 4'b0110, 32'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h3004, 4'b0100, 32'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0100, 32'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h400, 32'h400, 4'b0111, 32'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'h400, 32'h0, 32'h0, 32'h0, 32'h404, 4'b0100, 32'd4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0110, 32'h404, 32'h600, 32'h0, 32'h500, 32'h404, 4'b1100, 32'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0010, 32'h404, 32'h700, 32'h0, 32'h0, 32'h500, 4'b0111, 32'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'h500, 32'h0, 32'h0, 32'h0, 32'h504, 4'b0100, 32'd5));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 32'h504, 32'h0, 32'h800, 32'h0, 32'h504, 4'b1100, 32'd5));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 32'h504, 32'h0, 32'h900, 32'h0, 32'h504, 4'b1100, 32'd5));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'h504, 32'h0, 32'h0, 32'h0, 32'h800, 4'b0110, 32'd5));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 32'h800, 32'h0, 32'h0, 32'h0, 32'h804, 4'b0100, 32'd6));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 4'b0010, 32'h804, 32'hA00, 32'h0, 32'h0, 32'h804, 4'b1100, 32'd6));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'b0000, 32'h804, 32'h0, 32'h0, 32'h0, RESET_PC, 4'b1000, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0, RESET_PC, 4'b1000, 32'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0, 32'hF000_0004, 4'b0100, 32'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].hz, tbl[i].src, tbl[i].pc, tbl[i].brt, tbl[i].jt, tbl[i].ep);
      chk($sformatf("vec%0d.pc_in", i), bus.pc_in, tbl[i].e_pc);
      chk($sformatf("vec%0d.flags", i),
          {28'd0, bus.pc_stall, bus.imem_req, bus.flush_if, bus.flush_id}, {28'd0, tbl[i].e_flags});
      if (!tbl[i].rst) begin
        chk($sformatf("vec%0d.redirect_cnt", i), bus.redirect_cnt, tbl[i].e_cnt);
        chk($sformatf("vec%0d.if_timeout", i), {31'd0, bus.if_timeout}, 32'd0);
      end
    end

    // Fetch that never completes: timeout rises after the 4th WAIT cycle and sticks
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'hF000_0004, 32'h0, 32'h0, 32'h0);
      chk($sformatf("tmo%0d.if_timeout", k), {31'd0, bus.if_timeout}, (k >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("tmo%0d.flags", k), {30'd0, bus.pc_stall, bus.imem_req}, 32'd3);
    end
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'hF000_0004, 32'h0, 32'h0, 32'h0);
    chk("tmo_ack.pc_in", bus.pc_in, 32'hF000_0008);
    chk("tmo_ack.if_timeout", {31'd0, bus.if_timeout}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 4'b0000, 32'hF000_0008, 32'h0, 32'h0, 32'h0);
    chk("tmo_sticky.if_timeout", {31'd0, bus.if_timeout}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'hF000_000C, 32'h0, 32'h0, 32'h0);
    chk_reset_outputs("tmo_rst");
    drive(1'b0, 1'b0, 1'b0, 4'b0000, RESET_PC, 32'h0, 32'h0, 32'h0);
    chk("tmo_clr.if_timeout", {31'd0, bus.if_timeout}, 32'd0);

    // Randomized traffic against the reference model; PC register fed from expected pc_in
    next_pc = RESET_PC;
    for (int i = 0; i < 4000; i++) begin
      rst = (i < 2) || ($urandom_range(0, 249) == 0);
      ack = ($urandom_range(0, 3) != 0);
      hz  = ($urandom_range(0, 3) == 0);
      src = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      pc  = next_pc;
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
      tg[3] = EXC_VEC;
      tg[2] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tg[1] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tg[0] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drive(rst, ack, hz, src, pc, tg[1], tg[0], tg[2]);

      if (rst) begin
        chk_reset_outputs($sformatf("rnd%0d.rst", i));
        m_pend = -1; m_ptgt = 32'd0; m_boot = 1'b1; m_waits = 0; m_tmo = 1'b0; m_cnt = 32'd0;
        next_pc = RESET_PC;
      end else begin
        live = -1;
        for (int l = 3; l >= 0; l--) if (src[l] && live < 0) live = l;
        eff  = live;
        etgt = (live >= 0) ? tg[live] : 32'd0;
        if (m_pend >= 0 && m_pend >= live) begin
          eff  = m_pend;
          etgt = m_ptgt;
        end
        adv    = !m_boot && ack && (!hz || eff >= 2);
        exp_pc = m_boot ? RESET_PC : (!adv ? pc : ((eff >= 0) ? etgt : pc + 32'd4));

        chk($sformatf("rnd%0d.pc_in", i), bus.pc_in, exp_pc);
        chk($sformatf("rnd%0d.pc_stall", i), {31'd0, bus.pc_stall}, {31'd0, !adv});
        chk($sformatf("rnd%0d.imem_req", i), {31'd0, bus.imem_req}, {31'd0, !m_boot});
        chk($sformatf("rnd%0d.flush_if", i), {31'd0, bus.flush_if}, {31'd0, adv && eff >= 0});
        chk($sformatf("rnd%0d.flush_id", i), {31'd0, bus.flush_id}, {31'd0, adv && eff >= 1});
        chk($sformatf("rnd%0d.if_timeout", i), {31'd0, bus.if_timeout}, {31'd0, m_tmo});
        chk($sformatf("rnd%0d.redirect_cnt", i), bus.redirect_cnt, m_cnt);

        if (adv) begin
          if (eff >= 0) m_cnt = m_cnt + 32'd1;
          m_pend = -1;
        end else if (live > m_pend) begin
          m_pend = live;
          m_ptgt = tg[live];
        end
        if (!m_boot && m_waits >= WLIM) m_tmo = 1'b1;
        if (m_boot) begin
          m_boot  = 1'b0;
          m_waits = 0;
        end else if (ack) begin
          m_waits = 0;
        end else begin
          m_waits++;
        end
        next_pc = exp_pc;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
